// File: rtl/delta_counter_pkg.sv
// Shared types for the delta counter family.
package delta_counter_pkg;

  typedef enum logic {
    CNT_WRAP     = 1'b0,
    CNT_SATURATE = 1'b1
  } cnt_mode_e;

endpackage

// File: rtl/delta_counter_chan.sv
// One up/down delta counter channel with load/clear, wrap or saturate
// arithmetic, overflow flag and registered threshold-crossing pulse.
module delta_counter_chan
  import delta_counter_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter cnt_mode_e   MODE            = CNT_WRAP,
  parameter bit          STICKY_OVERFLOW = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] delta_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] thresh_i,
  output logic [WIDTH-1:0] q_o,
  output logic             overflow_o,
  output logic             match_o
);

  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] q_upd;
  logic             ovf_upd;
  logic             match_upd;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum       = '0;
    ovf       = 1'b0;
    q_upd     = q_o;
    ovf_upd   = overflow_o;
    match_upd = 1'b0;

    if (down_i) sum = {1'b0, q_o} - {1'b0, delta_i};
    else        sum = {1'b0, q_o} + {1'b0, delta_i};
    ovf = sum[WIDTH];

    // A clamped result still counts as a crossing; a wrapped one never does.
    if (MODE == CNT_SATURATE && ovf) q_upd = down_i ? '0 : '1;
    else                             q_upd = sum[WIDTH-1:0];

    if (down_i) match_upd = (q_o > thresh_i) && (q_upd <= thresh_i);
    else        match_upd = (q_o < thresh_i) && (q_upd >= thresh_i);
    if (ovf && MODE == CNT_WRAP) match_upd = 1'b0;

    ovf_upd = STICKY_OVERFLOW ? (overflow_o | ovf) : ovf;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o        <= '0;
      overflow_o <= 1'b0;
      match_o    <= 1'b0;
    end else if (clear_i) begin
      q_o        <= '0;
      overflow_o <= 1'b0;
      match_o    <= 1'b0;
    end else if (load_i) begin
      q_o        <= d_i;
      overflow_o <= 1'b0;
      match_o    <= 1'b0;
    end else if (en_i) begin
      q_o        <= q_upd;
      overflow_o <= ovf_upd;
      match_o    <= match_upd;
    end else begin
      match_o    <= 1'b0;
    end
  end

endmodule

// File: rtl/delta_counter_bank.sv
// Bank of NUM_CNT independent delta counter channels sharing one clock/reset.
module delta_counter_bank
  import delta_counter_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned NUM_CNT         = 4,
  parameter cnt_mode_e   MODE            = CNT_WRAP,
  parameter bit          STICKY_OVERFLOW = 1'b0
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_CNT-1:0]              clear_i,
  input  logic [NUM_CNT-1:0]              en_i,
  input  logic [NUM_CNT-1:0]              load_i,
  input  logic [NUM_CNT-1:0]              down_i,
  input  logic [NUM_CNT-1:0][WIDTH-1:0]   delta_i,
  input  logic [NUM_CNT-1:0][WIDTH-1:0]   d_i,
  input  logic [NUM_CNT-1:0][WIDTH-1:0]   thresh_i,
  output logic [NUM_CNT-1:0][WIDTH-1:0]   q_o,
  output logic [NUM_CNT-1:0]              overflow_o,
  output logic [NUM_CNT-1:0]              match_o
);

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_chan
    delta_counter_chan #(
      .WIDTH          (WIDTH),
      .MODE           (MODE),
      .STICKY_OVERFLOW(STICKY_OVERFLOW)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (clear_i[i]),
      .en_i      (en_i[i]),
      .load_i    (load_i[i]),
      .down_i    (down_i[i]),
      .delta_i   (delta_i[i]),
      .d_i       (d_i[i]),
      .thresh_i  (thresh_i[i]),
      .q_o       (q_o[i]),
      .overflow_o(overflow_o[i]),
      .match_o   (match_o[i])
    );
  end

endmodule

// File: tb/tb_delta_counter_bank.sv
// Drives a wrap/transient bank and a saturate/sticky bank with identical
// stimulus and compares both against an arithmetic reference model.
module tb_delta_counter_bank;
  import delta_counter_pkg::*;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [N-1:0] clear, en, load, down;
  logic [N-1:0][W-1:0] delta, d, thr;
  logic [N-1:0][W-1:0] q_a, q_b;
  logic [N-1:0] ovf_a, ovf_b, m_a, m_b;

  int errors = 0;
  int checks = 0;

  // Model state: index 0 = wrap/transient bank, 1 = saturate/sticky bank.
  int unsigned mq[2][N];
  bit          mo[2][N];
  bit          mm[2][N];

  always #5 clk = ~clk;

  delta_counter_bank #(.WIDTH(W), .NUM_CNT(N), .MODE(CNT_WRAP), .STICKY_OVERFLOW(1'b0)) u_wrap (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .en_i(en), .load_i(load), .down_i(down),
    .delta_i(delta), .d_i(d), .thresh_i(thr), .q_o(q_a), .overflow_o(ovf_a), .match_o(m_a)
  );

  delta_counter_bank #(.WIDTH(W), .NUM_CNT(N), .MODE(CNT_SATURATE), .STICKY_OVERFLOW(1'b1)) u_sat (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .en_i(en), .load_i(load), .down_i(down),
    .delta_i(delta), .d_i(d), .thresh_i(thr), .q_o(q_b), .overflow_o(ovf_b), .match_o(m_b)
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < N; c++) begin
        mq[k][c] = 0; mo[k][c] = 0; mm[k][c] = 0;
      end
  endtask

  // Applies the current inputs to the model as the next rising edge will.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < N; c++) begin
        int r, nq, q, t;
        bit ev, sat;
        sat = (k == 1);
        q = int'(mq[k][c]);
        t = int'(thr[c]);
        if (clear[c]) begin
          mq[k][c] = 0; mo[k][c] = 0; mm[k][c] = 0;
        end else if (load[c]) begin
          mq[k][c] = d[c]; mo[k][c] = 0; mm[k][c] = 0;
        end else if (en[c]) begin
          r  = down[c] ? q - int'(delta[c]) : q + int'(delta[c]);
          ev = (r < 0) || (r > MAX);
          if (sat && ev) nq = down[c] ? 0 : MAX;
          else           nq = (r + MAX + 1) % (MAX + 1);
          mm[k][c] = !(ev && !sat) && (down[c] ? (q > t && nq <= t) : (q < t && nq >= t));
          mo[k][c] = sat ? (mo[k][c] | ev) : ev;
          mq[k][c] = nq;
        end else begin
          mm[k][c] = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] oq;
    logic oo, om;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < N; c++) begin
        oq = (k == 0) ? q_a[c]   : q_b[c];
        oo = (k == 0) ? ovf_a[c] : ovf_b[c];
        om = (k == 0) ? m_a[c]   : m_b[c];
        checks++;
        assert (oq === W'(mq[k][c])) else begin
          errors++;
          $error("FAIL %s q bank%0d ch%0d observed=%0d expected=%0d", tag, k, c, oq, mq[k][c]);
        end
        checks++;
        assert (oo === mo[k][c]) else begin
          errors++;
          $error("FAIL %s overflow bank%0d ch%0d observed=%0b expected=%0b", tag, k, c, oo, mo[k][c]);
        end
        checks++;
        assert (om === mm[k][c]) else begin
          errors++;
          $error("FAIL %s match bank%0d ch%0d observed=%0b expected=%0b", tag, k, c, om, mm[k][c]);
        end
      end
    end
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle();
    clear = '0; en = '0; load = '0; down = '0;
    delta = '0; d = '0;
  endtask

  task automatic ch0(input bit ld, input bit e, input bit dn,
                     input int unsigned val, input int unsigned th);
    idle();
    load[0] = ld; en[0] = e; down[0] = dn;
    d[0] = W'(val); delta[0] = W'(val); thr[0] = W'(th);
  endtask

  initial begin
    idle();
    thr = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_ni = 1'b1;

    // Carry and transient clearing of the flag.
    ch0(1, 0, 0, 254, 0); cycle("load254");
    ch0(0, 1, 0, 3,   0); cycle("up3_carry");
    ch0(0, 1, 0, 1,   0); cycle("up1_after_carry");

    // Borrow, sticky flag, load clears it.
    ch0(1, 0, 0, 2, 0); cycle("load2");
    ch0(0, 1, 1, 5, 0); cycle("down5_borrow");
    ch0(0, 1, 0, 4, 0); cycle("up4_sticky");
    ch0(1, 0, 0, 0, 0); cycle("load0_clears");

    // Up crossing: single-cycle pulse.
    ch0(1, 0, 0, 7,  10); cycle("load7");
    ch0(0, 1, 0, 3,  10); cycle("up_cross");
    ch0(0, 1, 0, 1,  10); cycle("up_past");
    ch0(0, 0, 0, 0,  10); cycle("hold_nopulse");

    // Down crossing, then wrapping borrow suppresses match.
    ch0(1, 0, 0, 9, 5); cycle("load9");
    ch0(0, 1, 1, 4, 5); cycle("down_cross");
    ch0(1, 0, 0, 2, 5); cycle("load2b");
    ch0(0, 1, 1, 4, 5); cycle("down_wrap");

    // Saturating clamp onto an all-ones threshold.
    ch0(1, 0, 0, 250, MAX); cycle("load250");
    ch0(0, 1, 0, 10,  MAX); cycle("clamp_match");

    // Zero delta: no change, no match, transient flag clears.
    ch0(0, 1, 0, 0, MAX); cycle("delta0");

    // Per-channel priority in one cycle.
    idle(); load = '1;
    for (int c = 0; c < N; c++) d[c] = W'(20 + 10 * c);
    cycle("preload");
    idle();
    for (int c = 0; c < N; c++) begin d[c] = W'(100 + c); delta[c] = W'(3); end
    clear[0] = 1; load[0] = 1; en[0] = 1;
    load[1] = 1; en[1] = 1;
    en[2] = 1;
    cycle("priority");

    // Asynchronous reset between edges while every channel is enabled.
    idle(); en = '1;
    for (int c = 0; c < N; c++) delta[c] = W'(5 + c);
    #1 rst_ni = 1'b0;
    #1 model_reset();
    check_all("rst_async");
    en = '0;
    #1 rst_ni = 1'b1;
    model_step();
    @(posedge clk); #1;
    check_all("rst_release_noupd");
    @(negedge clk);
    en = '1;
    cycle("rst_first_update");

    // Randomised traffic; thresholds kept near the count so crossings occur.
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < N; c++) begin
        int t;
        clear[c] = ($urandom_range(0, 19) == 0);
        load[c]  = ($urandom_range(0, 9) == 0);
        en[c]    = ($urandom_range(0, 3) != 0);
        down[c]  = $urandom_range(0, 1) == 1;
        d[c]     = W'($urandom_range(0, MAX));
        case ($urandom_range(0, 3))
          0:       delta[c] = '0;
          1:       delta[c] = W'($urandom_range(0, MAX));
          default: delta[c] = W'($urandom_range(1, 8));
        endcase
        t = int'(mq[$urandom_range(0, 1)][c]) + $urandom_range(0, 16) - 8;
        if (t < 0) t = 0;
        if (t > MAX) t = MAX;
        thr[c] = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, MAX)) : W'(t);
      end
      cycle("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
